// File: rtl/latch_bank_ctrl_pkg.sv
// rtl/latch_bank_ctrl_pkg.sv - shared state encoding and parameter defaults for latch_bank_ctrl
//
// Purpose: defines the controller state type and the default bank geometry
// used by latch_bank_ctrl and its round-robin arbiter.
// Ports: none (package).
package latch_bank_ctrl_pkg;

  localparam int NREQ_DEF = 4;  // requesters sharing the bank
  localparam int DW_DEF   = 8;  // latch data width
  localparam int AW_DEF   = 2;  // latch address width, bank depth 2**AW

  // CLEAR and HOLD_CLR are only reachable when LATCH_BANK_CTRL_CLEAR_EN is built.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    WRITE    = 3'd2,
    HOLD     = 3'd3,
    CLEAR    = 3'd4,
    HOLD_CLR = 3'd5
  } state_t;

endpackage

// File: rtl/latch_bank_ctrl_rr_arbiter.sv
// rtl/latch_bank_ctrl_rr_arbiter.sv - round-robin requester arbiter with advance-on-completion pointer
//
// Purpose: combinationally selects the first asserted request at or after the
// round-robin pointer (wrapping NREQ-1 to 0). The pointer moves to the slot
// after the completed requester when advance_i is strobed.
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset, pointer returns to 0
//   req_i      per-requester request levels
//   advance_i  one-cycle strobe: move pointer past adv_id_i
//   adv_id_i   index of the requester whose write just completed
//   valid_o    at least one request is asserted
//   grant_o    index of the selected requester (valid when valid_o)
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            advance_i,
  input  logic [IW-1:0]   adv_id_i,
  output logic            valid_o,
  output logic [IW-1:0]   grant_o
);

  logic [IW-1:0]     ptr_q;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              valid_d;
  logic [IW-1:0]     grant_d;
  int                sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= (adv_id_i == IW'(NREQ - 1)) ? '0 : adv_id_i + 1'b1;
    end
  end

  // Rotating the doubled request vector puts the pointer slot at bit 0, so the
  // lowest set bit of rot is the round-robin winner.
  assign dbl = {req_i, req_i};
  assign rot = NREQ'(dbl >> ptr_q);

  always_comb begin
    valid_d = 1'b0;
    grant_d = '0;
    sum     = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid_d && rot[k]) begin
        sum = int'(ptr_q) + k;
        if (sum >= NREQ) sum = sum - NREQ;
        valid_d = 1'b1;
        grant_d = IW'(sum);
      end
    end
  end

  assign valid_o = valid_d;
  assign grant_o = grant_d;

endmodule

// File: rtl/latch_bank_ctrl.sv
// rtl/latch_bank_ctrl.sv - write sequencer for a shared bank of D-latch registers
//
// Purpose: arbitrates round-robin between requesters, captures the winner's
// data/address at grant, then drives the bank through SETUP (data on bus),
// WRITE (one-hot enable for one cycle) and HOLD (data held, ack pulse).
// lat_rst is high during reset and through the first edge after release.
// Optional macro LATCH_BANK_CTRL_CLEAR_EN adds a bank-clear request path.
// Ports:
//   clk       system clock, rising edge
//   reset_n   asynchronous active-low reset
//   req       per-requester write request (level)
//   wdata     requester data, requester i at [i*DW +: DW]
//   waddr     requester latch address, requester i at [i*AW +: AW]
//   ack       one-cycle one-hot write-done pulse
//   lat_d     shared data bus to the latch bank
//   lat_en    one-hot latch enable
//   lat_rst   active-high latch-bank reset
//   busy      transaction in progress
//   grant_id  index of current/last granted requester
//   clr_req   (LATCH_BANK_CTRL_CLEAR_EN) request a bank clear, wins over req
//   clr_ack   (LATCH_BANK_CTRL_CLEAR_EN) one-cycle clear-done pulse
module latch_bank_ctrl
  import latch_bank_ctrl_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  parameter  int DW   = DW_DEF,
  parameter  int AW   = AW_DEF,
  localparam int IW   = $clog2(NREQ),
  localparam int NL   = 2 ** AW
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ*AW-1:0] waddr,
`ifdef LATCH_BANK_CTRL_CLEAR_EN
  input  logic               clr_req,
  output logic               clr_ack,
`endif
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      lat_d,
  output logic [NL-1:0]      lat_en,
  output logic               lat_rst,
  output logic               busy,
  output logic [IW-1:0]      grant_id
);

  state_t          state_q;
  logic [NREQ-1:0] ack_q;
  logic [DW-1:0]   lat_d_q;
  logic [NL-1:0]   lat_en_q;
  logic            lat_rst_q;
  logic            busy_q;
  logic [IW-1:0]   grant_id_q;
  logic [AW-1:0]   addr_q;
  logic [NL-1:0]   en_dec;
  logic            arb_valid;
  logic [IW-1:0]   arb_grant;
`ifdef LATCH_BANK_CTRL_CLEAR_EN
  logic            clr_ack_q;
`endif

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (req),
    .advance_i (state_q == HOLD),
    .adv_id_i  (grant_id_q),
    .valid_o   (arb_valid),
    .grant_o   (arb_grant)
  );

  always_comb begin
    en_dec         = '0;
    en_dec[addr_q] = 1'b1;
  end

  // Outputs are registered alongside the state: each branch loads the output
  // values belonging to the state being entered. lat_d_q doubles as the
  // captured write data, so it is only loaded at grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      lat_d_q    <= '0;
      lat_en_q   <= '0;
      lat_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      grant_id_q <= '0;
      addr_q     <= '0;
`ifdef LATCH_BANK_CTRL_CLEAR_EN
      clr_ack_q  <= 1'b0;
`endif
    end else begin
      ack_q     <= '0;
      lat_en_q  <= '0;
      lat_rst_q <= 1'b0;
`ifdef LATCH_BANK_CTRL_CLEAR_EN
      clr_ack_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
`ifdef LATCH_BANK_CTRL_CLEAR_EN
          if (clr_req) begin
            state_q   <= CLEAR;
            lat_rst_q <= 1'b1;
            busy_q    <= 1'b1;
          end else
`endif
          if (arb_valid) begin
            state_q    <= SETUP;
            grant_id_q <= arb_grant;
            lat_d_q    <= wdata[arb_grant*DW +: DW];
            addr_q     <= waddr[arb_grant*AW +: AW];
            busy_q     <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SETUP: begin
          state_q  <= WRITE;
          lat_en_q <= en_dec;
        end
        WRITE: begin
          state_q           <= HOLD;
          ack_q[grant_id_q] <= 1'b1;
        end
        HOLD: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
`ifdef LATCH_BANK_CTRL_CLEAR_EN
        CLEAR: begin
          state_q   <= HOLD_CLR;
          clr_ack_q <= 1'b1;
        end
        HOLD_CLR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack      = ack_q;
  assign lat_d    = lat_d_q;
  assign lat_en   = lat_en_q;
  assign lat_rst  = lat_rst_q;
  assign busy     = busy_q;
  assign grant_id = grant_id_q;
`ifdef LATCH_BANK_CTRL_CLEAR_EN
  assign clr_ack  = clr_ack_q;
`endif

endmodule
